cell_free_list: RTL and testbench
=================================

// Module: cell_free_list
//
// PURPOSE
//   Parametrised free-list manager for the shared packet cell memory.
//   Hands out free cell indices to NUM_CH writer channels under round-robin arbitration.
//   Takes back indices released by the reader after a packet drains.
//   Sits between ingress cell writers (which chain cells via footer next_idx) and the
//   egress reader. Adds self-initialisation, double-free/range checking and a low-watermark flag.
//
// PARAMETERS
//   NUM_BLOCKS  64  number of cells in shared memory; need not be a power of two
//   ADDR_W      12  cell index width; must satisfy ADDR_W >= $clog2(NUM_BLOCKS)
//   NUM_CH      2   number of allocating channels (>=1)
//   LOW_WM      4   low_wm asserts when free_count <= LOW_WM
//
// PORTS
//   clk              in   1          single clock, all logic rising-edge
//   rst_n            in   1          asynchronous, active-low reset
//   init_done        out  1          free list populated, block operational
//   alloc_req        in   NUM_CH     per-channel request, held until granted
//   alloc_gnt        out  NUM_CH     one-hot grant; index consumed this cycle
//   alloc_idx        out  ADDR_W     granted cell index, valid when |alloc_gnt
//   free_valid       in   1          release a cell index this cycle
//   free_idx         in   ADDR_W     index being released
//   free_ready       out  1          = init_done; frees with free_ready=0 are ignored
//   free_count       out  ADDR_W+1   number of cells currently free (registered)
//   low_wm           out  1          init_done && free_count <= LOW_WM (registered)
//   err_double_free  out  1          1-cycle pulse: freed index not currently allocated
//   err_range        out  1          1-cycle pulse: free_idx >= NUM_BLOCKS
//
// BEHAVIOUR
//   - Reset values: init_done=0, alloc_gnt=0, alloc_idx=0, free_ready=0, free_count=0,
//     low_wm=0, err_*=0. Reset clears rd/wr pointers, in-use bitmap and RR pointer.
//   - Storage: circular FIFO of NUM_BLOCKS x ADDR_W entries (flops).
//     Pointers wrap explicitly at NUM_BLOCKS-1 -> 0.
//   - FSM INIT -> RUN. In INIT, cycle k writes index k to slot k, k = 0..NUM_BLOCKS-1.
//     The cycle after the last write: state=RUN, init_done=1, free_count=NUM_BLOCKS.
//     Alloc and free inputs are ignored in INIT.
//   - Alloc (RUN): gnt/idx are combinational from alloc_req, RR pointer and head slot.
//     Grant only when free_count>0.
//     Winner = first requesting channel at or after the RR pointer (cyclic).
//     On grant: pop head, set in-use bit, RR pointer <- winner+1 (mod NUM_CH).
//     Max one grant per cycle. alloc_idx=0 whenever no grant.
//   - Free (RUN): free_idx >= NUM_BLOCKS -> dropped, err_range pulse next cycle.
//     In-use bit clear -> dropped, err_double_free pulse next cycle.
//     Otherwise push at tail and clear the in-use bit.
//     Overflow is therefore impossible.
//   - Simultaneous alloc+free: both take effect; free_count unchanged.
//     No bypass: with free_count==0 a same-cycle free does not enable a grant.
//     The freed index is grantable next cycle.
//   - Same index freed and ... n/a: an index cannot be granted and freed in one cycle,
//     because a grant requires its in-use bit to be clear at the head.
//   - free_count and low_wm update on the clock edge after the alloc/free event.
//   - Reset asserted mid-operation: all state is discarded and INIT reruns.
//     Outstanding allocations are forgotten; all cells are free again.
//
// TESTING
//   1. Release rst_n -> init_done rises exactly 64 cycles later; free_count=64, low_wm=0.
//   2. ch0 requests continuously -> idx 0,1,..,63 granted on consecutive cycles.
//      low_wm=1 once free_count<=4. free_count=0, then no further gnt.
//   3. ch0 and ch1 both request continuously -> gnt alternates 01,10,01,...
//      with idx 0,1,2,...
//   4. Alloc idx 5, free 5, free 5 again -> 2nd free: 1-cycle err_double_free,
//      free_count unchanged. Free 70 -> err_range pulse.
//   5. List empty; same cycle free 7 + ch1 req -> no gnt that cycle;
//      next cycle gnt=10, idx=7, free_count returns to 0.
//   6. rst_n low after 10 grants -> outputs at reset values;
//      re-init completes, first grant idx=0, free_count=64.

Source files
------------

// File: rtl/cell_free_list_if.sv
// Allocation/release bus between the cell free-list manager, the ingress
// cell writers (allocating channels) and the egress reader (releasing side).
interface cell_free_list_if #(
  parameter int ADDR_W = 12,
  parameter int NUM_CH = 2
);
  logic              init_done;
  logic [NUM_CH-1:0] alloc_req;
  logic [NUM_CH-1:0] alloc_gnt;
  logic [ADDR_W-1:0] alloc_idx;
  logic              free_valid;
  logic [ADDR_W-1:0] free_idx;
  logic              free_ready;
  logic [ADDR_W:0]   free_count;
  logic              low_wm;
  logic              err_double_free;
  logic              err_range;

  modport master (
    output alloc_req, free_valid, free_idx,
    input  init_done, alloc_gnt, alloc_idx, free_ready, free_count,
           low_wm, err_double_free, err_range
  );

  modport slave (
    input  alloc_req, free_valid, free_idx,
    output init_done, alloc_gnt, alloc_idx, free_ready, free_count,
           low_wm, err_double_free, err_range
  );
endinterface

// File: rtl/cell_free_list.sv
// Free-list manager for the shared packet cell memory: self-initialising
// circular FIFO of free indices, round-robin allocation and checked release.
module cell_free_list #(
  parameter int NUM_BLOCKS = 64,
  parameter int ADDR_W     = 12,
  parameter int NUM_CH     = 2,
  parameter int LOW_WM     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cell_free_list_if.slave  bus
);

  localparam int PTR_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_BLOCKS - 1);
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(NUM_BLOCKS);
  localparam logic [ADDR_W:0]  LOW_CNT  = (ADDR_W + 1)'(LOW_WM);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              init_last_s;
  logic [ADDR_W-1:0] slot_r [NUM_BLOCKS];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_nxt_s;
  logic [NUM_BLOCKS-1:0] in_use_r;
  logic [CH_W-1:0]   rr_ptr_r;
  logic [CH_W-1:0]   rr_nxt_s;
  logic [CH_W-1:0]   cand_s;
  logic [NUM_CH-1:0] gnt_s;
  logic [ADDR_W-1:0] head_s;
  logic              pop_s;
  logic              push_s;
  logic              range_s;
  logic              dbl_s;
  logic [PTR_W-1:0]  free_ptr_s;
  logic              low_wm_r;
  logic              err_dbl_r;
  logic              err_rng_r;

  // Wraps explicitly so NUM_BLOCKS need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: INIT walks the write pointer over every slot once.
  always_comb begin
    state_nxt_s = state_r;
    init_last_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (wr_ptr_r == LAST_PTR) begin
          state_nxt_s = ST_RUN;
          init_last_s = 1'b1;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_INIT;
    endcase
  end

  // Round-robin winner among requesters, starting at the RR pointer.
  always_comb begin
    gnt_s    = '0;
    pop_s    = 1'b0;
    rr_nxt_s = rr_ptr_r;
    cand_s   = '0;
    head_s   = slot_r[rd_ptr_r];
    if ((state_r == ST_RUN) && (count_r != '0)) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cand_s = CH_W'((int'(rr_ptr_r) + i) % NUM_CH);
        if (!pop_s && bus.alloc_req[cand_s]) begin
          pop_s         = 1'b1;
          gnt_s[cand_s] = 1'b1;
          rr_nxt_s      = CH_W'((int'(cand_s) + 1) % NUM_CH);
        end else begin
          pop_s = pop_s;
        end
      end
    end else begin
      pop_s = 1'b0;
    end
  end

  // Release checks: out-of-range first, then not-currently-allocated.
  always_comb begin
    range_s    = 1'b0;
    dbl_s      = 1'b0;
    push_s     = 1'b0;
    free_ptr_s = bus.free_idx[PTR_W-1:0];
    if ((state_r == ST_RUN) && bus.free_valid) begin
      if ({1'b0, bus.free_idx} >= FULL_CNT) begin
        range_s = 1'b1;
      end else if (!in_use_r[free_ptr_s]) begin
        dbl_s = 1'b1;
      end else begin
        push_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
  end

  // Free count after this cycle's alloc/free; simultaneous events cancel.
  always_comb begin
    count_nxt_s = count_r;
    if (init_last_s) begin
      count_nxt_s = FULL_CNT;
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + (ADDR_W + 1)'(1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - (ADDR_W + 1)'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // FIFO storage, pointers, in-use bitmap and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        slot_r[i] <= '0;
      end
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      count_r   <= '0;
      in_use_r  <= '0;
      rr_ptr_r  <= '0;
      low_wm_r  <= 1'b0;
      err_dbl_r <= 1'b0;
      err_rng_r <= 1'b0;
    end else begin
      if (state_r == ST_INIT) begin
        slot_r[wr_ptr_r] <= ADDR_W'(wr_ptr_r);
        wr_ptr_r         <= ptr_inc(wr_ptr_r);
      end else begin
        if (pop_s) begin
          rd_ptr_r                     <= ptr_inc(rd_ptr_r);
          in_use_r[head_s[PTR_W-1:0]]  <= 1'b1;
          rr_ptr_r                     <= rr_nxt_s;
        end
        if (push_s) begin
          slot_r[wr_ptr_r]     <= bus.free_idx;
          wr_ptr_r             <= ptr_inc(wr_ptr_r);
          in_use_r[free_ptr_s] <= 1'b0;
        end
      end
      count_r   <= count_nxt_s;
      low_wm_r  <= (state_nxt_s == ST_RUN) && (count_nxt_s <= LOW_CNT);
      err_dbl_r <= dbl_s;
      err_rng_r <= range_s;
    end
  end

  assign bus.init_done       = (state_r == ST_RUN);
  assign bus.free_ready      = (state_r == ST_RUN);
  assign bus.alloc_gnt       = gnt_s;
  assign bus.alloc_idx       = pop_s ? head_s : '0;
  assign bus.free_count      = count_r;
  assign bus.low_wm          = low_wm_r;
  assign bus.err_double_free = err_dbl_r;
  assign bus.err_range       = err_rng_r;

endmodule

// File: tb/tb_cell_free_list.sv
// Self-checking bench for cell_free_list: directed scenarios plus randomized
// traffic against a queue-based model of the free list.
module tb_cell_free_list;
  localparam int NUM_BLOCKS = 64;
  localparam int ADDR_W     = 12;
  localparam int NUM_CH     = 2;
  localparam int LOW_WM     = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cell_free_list_if #(.ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) bus ();

  cell_free_list #(
    .NUM_BLOCKS(NUM_BLOCKS), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .LOW_WM(LOW_WM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // reference model: queue of free indices in hand-out order
  int  fq[$];
  bit  used [NUM_BLOCKS];
  int  rr;
  bit  run;
  int  win;
  logic [NUM_CH-1:0] cur_req;
  bit  cur_fv;
  int  cur_fidx;
  logic [NUM_CH-1:0] exp_gnt;
  logic [ADDR_W-1:0] exp_idx;
  int  exp_count;
  bit  exp_low, exp_dbl, exp_rng;
  int  n_vec = 0;
  int  n_err = 0;

  function automatic logic [ADDR_W+3:0] exp_regs();
    return {(ADDR_W + 1)'(exp_count), exp_low, exp_dbl, exp_rng};
  endfunction

  function automatic logic [ADDR_W+3:0] dut_regs();
    return {bus.free_count, bus.low_wm, bus.err_double_free, bus.err_range};
  endfunction

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < NUM_BLOCKS; i++) used[i] = 1'b0;
    rr = 0; run = 1'b0; exp_count = 0;
    exp_low = 1'b0; exp_dbl = 1'b0; exp_rng = 1'b0;
  endtask

  task automatic model_init();
    model_reset();
    for (int i = 0; i < NUM_BLOCKS; i++) fq.push_back(i);
    run = 1'b1; exp_count = NUM_BLOCKS; exp_low = (NUM_BLOCKS <= LOW_WM);
  endtask

  // Drive one cycle's inputs and predict the combinational grant.
  task automatic apply(input logic [NUM_CH-1:0] req, input bit fv, input int fidx);
    cur_req = req; cur_fv = fv; cur_fidx = fidx;
    bus.alloc_req  = req;
    bus.free_valid = fv;
    bus.free_idx   = ADDR_W'(fidx);
    #1;
    win = -1; exp_gnt = '0; exp_idx = '0;
    if (run && fq.size() > 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        int c;
        c = (rr + i) % NUM_CH;
        if (win < 0 && req[c]) win = c;
      end
    end
    if (win >= 0) begin
      exp_gnt[win] = 1'b1;
      exp_idx = ADDR_W'(fq[0]);
    end
  endtask

  // Advance one clock and update the model with the applied inputs.
  task automatic tick();
    bit ok_free;
    int g;
    ok_free = 1'b0; exp_dbl = 1'b0; exp_rng = 1'b0;
    @(posedge clk); #1;
    if (run) begin
      if (cur_fv) begin
        if (cur_fidx >= NUM_BLOCKS) exp_rng = 1'b1;
        else if (!used[cur_fidx]) exp_dbl = 1'b1;
        else ok_free = 1'b1;
      end
      if (win >= 0) begin
        g = fq.pop_front();
        used[g] = 1'b1;
        rr = (win + 1) % NUM_CH;
      end
      if (ok_free) begin
        fq.push_back(cur_fidx);
        used[cur_fidx] = 1'b0;
      end
    end
    exp_count = run ? fq.size() : 0;
    exp_low   = run && (exp_count <= LOW_WM);
  endtask

  task automatic wait_init(output int cycles);
    cycles = 0;
    while (!bus.init_done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset();
    int cycles;
    logic [NUM_CH+ADDR_W+ADDR_W+1:0] quiet;
    rst_n = 1'b0;
    bus.alloc_req = '1; bus.free_valid = 1'b1; bus.free_idx = ADDR_W'(3);
    model_reset();
    #3;
    n_vec++;
    if ({bus.init_done, bus.free_ready, bus.alloc_gnt, bus.alloc_idx, dut_regs()} !== '0) begin
      n_err++;
      $display("FAIL reset_vals: got done=%b rdy=%b gnt=%b idx=%0d regs=%h, want all zero",
               bus.init_done, bus.free_ready, bus.alloc_gnt, bus.alloc_idx, dut_regs());
    end
    @(negedge clk); rst_n = 1'b1;
    cycles = 0;
    while (!bus.init_done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (!bus.init_done) begin
        quiet = {bus.alloc_gnt, bus.alloc_idx, bus.err_double_free, bus.free_count};
        n_vec++;
        if (quiet !== '0) begin
          n_err++;
          $display("FAIL init_ignores_inputs: cycle %0d got %h want 0", cycles, quiet);
        end
      end
    end
    bus.alloc_req = '0; bus.free_valid = 1'b0; bus.free_idx = '0;
    n_vec++;
    if (cycles != 64) begin
      n_err++;
      $display("FAIL init_latency: got %0d cycles want 64", cycles);
    end
    model_init();
    n_vec++;
    if (dut_regs() !== exp_regs() || bus.free_ready !== 1'b1) begin
      n_err++;
      $display("FAIL init_regs: got regs=%h rdy=%b want regs=%h rdy=1", dut_regs(), bus.free_ready, exp_regs());
    end
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < 10; i++) begin
      apply(2'b11, 1'b0, 0);
      n_vec++;
      if (bus.alloc_gnt !== exp_gnt || bus.alloc_idx !== exp_idx || exp_idx !== ADDR_W'(i)) begin
        n_err++;
        $display("FAIL rr_grant %0d: got gnt=%b idx=%0d want gnt=%b idx=%0d", i,
                 bus.alloc_gnt, bus.alloc_idx, exp_gnt, i);
      end
      tick();
      n_vec++;
      if (dut_regs() !== exp_regs()) begin
        n_err++;
        $display("FAIL rr_regs %0d: got %h want %h", i, dut_regs(), exp_regs());
      end
    end
  endtask

  task automatic test_reset_mid();
    int cycles;
    bus.alloc_req = '1;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({bus.init_done, bus.free_ready, bus.alloc_gnt, bus.alloc_idx, dut_regs()} !== '0) begin
      n_err++;
      $display("FAIL midreset_vals: got done=%b gnt=%b idx=%0d regs=%h want all zero",
               bus.init_done, bus.alloc_gnt, bus.alloc_idx, dut_regs());
    end
    @(negedge clk); rst_n = 1'b1;
    wait_init(cycles);
    n_vec++;
    if (cycles != 64) begin
      n_err++;
      $display("FAIL midreset_latency: got %0d cycles want 64", cycles);
    end
    model_init();
    n_vec++;
    if (dut_regs() !== exp_regs()) begin
      n_err++;
      $display("FAIL midreset_count: got %h want %h", dut_regs(), exp_regs());
    end
    apply(2'b01, 1'b0, 0);
    n_vec++;
    if (bus.alloc_gnt !== 2'b01 || bus.alloc_idx !== ADDR_W'(0)) begin
      n_err++;
      $display("FAIL midreset_first_grant: got gnt=%b idx=%0d want gnt=01 idx=0", bus.alloc_gnt, bus.alloc_idx);
    end
    bus.alloc_req = '0;
  endtask

  task automatic test_sequential_alloc();
    for (int i = 0; i < NUM_BLOCKS + 3; i++) begin
      apply(2'b01, 1'b0, 0);
      n_vec++;
      if (bus.alloc_gnt !== exp_gnt || bus.alloc_idx !== exp_idx ||
          (i < NUM_BLOCKS && exp_idx !== ADDR_W'(i))) begin
        n_err++;
        $display("FAIL seq_grant %0d: got gnt=%b idx=%0d want gnt=%b idx=%0d", i,
                 bus.alloc_gnt, bus.alloc_idx, exp_gnt, exp_idx);
      end
      tick();
      n_vec++;
      if (dut_regs() !== exp_regs()) begin
        n_err++;
        $display("FAIL seq_regs %0d: got %h want %h", i, dut_regs(), exp_regs());
      end
    end
  endtask

  task automatic test_empty_free();
    apply(2'b10, 1'b1, 7);
    n_vec++;
    if (bus.alloc_gnt !== '0 || exp_gnt !== '0) begin
      n_err++;
      $display("FAIL nobypass_gnt: got %b want 00", bus.alloc_gnt);
    end
    tick();
    n_vec++;
    if (dut_regs() !== exp_regs()) begin
      n_err++;
      $display("FAIL nobypass_regs: got %h want %h", dut_regs(), exp_regs());
    end
    apply(2'b10, 1'b0, 0);
    n_vec++;
    if (bus.alloc_gnt !== 2'b10 || bus.alloc_idx !== ADDR_W'(7)) begin
      n_err++;
      $display("FAIL refill_grant: got gnt=%b idx=%0d want gnt=10 idx=7", bus.alloc_gnt, bus.alloc_idx);
    end
    tick();
    n_vec++;
    if (dut_regs() !== exp_regs() || bus.free_count !== '0) begin
      n_err++;
      $display("FAIL refill_regs: got %h want %h", dut_regs(), exp_regs());
    end
  endtask

  task automatic test_double_free_range();
    int fi [5] = '{5, 5, 0, 70, 0};
    bit fv [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(2'b00, fv[i], fi[i]);
      tick();
      n_vec++;
      if (dut_regs() !== exp_regs()) begin
        n_err++;
        $display("FAIL free_check step %0d: got regs=%h want %h", i, dut_regs(), exp_regs());
      end
    end
  endtask

  task automatic test_random();
    int alloc_list[$];
    int r;
    logic [NUM_CH-1:0] req;
    bit fv;
    int fidx;
    bit heavy_alloc;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      heavy_alloc = ((cyc / 250) % 2) == 0;
      alloc_list.delete();
      for (int k = 0; k < NUM_BLOCKS; k++) if (used[k]) alloc_list.push_back(k);
      req = NUM_CH'($urandom_range(0, 3));
      if (!heavy_alloc && $urandom_range(0, 1) == 0) req = '0;
      r = $urandom_range(0, 9);
      fv = 1'b0; fidx = 0;
      if (r < (heavy_alloc ? 3 : 6) && alloc_list.size() > 0) begin
        fv = 1'b1; fidx = alloc_list[$urandom_range(0, alloc_list.size() - 1)];
      end else if (r == 7) begin
        fv = 1'b1; fidx = $urandom_range(0, NUM_BLOCKS - 1);
      end else if (r == 8) begin
        fv = 1'b1; fidx = $urandom_range(NUM_BLOCKS, 4095);
      end
      apply(req, fv, fidx);
      n_vec++;
      if (bus.alloc_gnt !== exp_gnt || bus.alloc_idx !== exp_idx) begin
        n_err++;
        $display("FAIL rand_grant %0d: got gnt=%b idx=%0d want gnt=%b idx=%0d", cyc,
                 bus.alloc_gnt, bus.alloc_idx, exp_gnt, exp_idx);
      end
      tick();
      n_vec++;
      if (dut_regs() !== exp_regs() || bus.init_done !== 1'b1 || bus.free_ready !== 1'b1) begin
        n_err++;
        $display("FAIL rand_regs %0d: got regs=%h done=%b want regs=%h done=1", cyc,
                 dut_regs(), bus.init_done, exp_regs());
      end
    end
  endtask

  initial begin
    bus.alloc_req  = '0;
    bus.free_valid = 1'b0;
    bus.free_idx   = '0;
    test_reset();
    test_round_robin();
    test_reset_mid();
    test_sequential_alloc();
    test_empty_free();
    test_double_free_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
